// File: rtl/cdc_hs_pkg.sv
// Shared types for the source side of the 4-phase req/ack crossing.
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_t;

endpackage

// File: rtl/metastability_filter.sv
// Multi-flop synchroniser for a single asynchronous level signal.
module metastability_filter #(
  parameter int NB_STAGES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [NB_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[NB_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[NB_STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack crossing: holds one word on o_data while
// o_req is raised and released against the synchronised acknowledge.
module cdc_handshake_tx
  import cdc_hs_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NB_STAGES = 3,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_req,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ack,
  output logic              o_done,
  output logic              o_timeout,
  output logic              o_busy
);

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               done_q, done_d;
  logic               ack_s;

  metastability_filter #(
    .NB_STAGES(NB_STAGES)
  ) u_ack_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (i_ack),
    .q_o  (ack_s)
  );

  // A stale-high ack (e.g. after a mid-handshake reset) blocks new words.
  assign o_ready = (state_q == IDLE) & ~ack_s;
  assign o_busy  = (state_q != IDLE);
  assign o_req   = req_q;
  assign o_data  = data_q;
  assign o_done  = done_q;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid && o_ready) begin
          data_d  = i_data;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = REL;
        end
      end
      REL: begin
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_tmo
      localparam int                CNT_W   = $clog2(TIMEOUT + 1);
      localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT);

      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             tmo_q, tmo_d;

      // A state change wins over a coinciding expiry: the counter restarts silently.
      always_comb begin
        cnt_d = cnt_q;
        tmo_d = 1'b0;
        if (state_d != state_q) begin
          cnt_d = '0;
        end else if (state_q != IDLE && cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
          tmo_d = (cnt_d == CNT_MAX);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
          tmo_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          tmo_q <= tmo_d;
        end
      end

      assign o_timeout = tmo_q;
    end else begin : g_no_tmo
      assign o_timeout = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx (NB_STAGES=3, TIMEOUT=16).
module tb_cdc_handshake_tx;

  localparam int DATA_W = 8;
  localparam int NB     = 3;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_valid = 1'b0;
  logic [DATA_W-1:0] i_data = '0;
  logic              man_ack = 1'b0;
  logic              dest_ack = 1'b0;
  logic              dest_en = 1'b0;
  logic              dest_jit = 1'b0;
  logic              ack_w;
  logic              o_ready, o_req, o_done, o_timeout, o_busy;
  logic [DATA_W-1:0] o_data;

  int n_cmp = 0;
  int n_bad = 0;
  int dest_cnt = 0;

  assign ack_w = dest_en ? dest_ack : man_ack;

  cdc_handshake_tx #(
    .DATA_W   (DATA_W),
    .NB_STAGES(NB),
    .TIMEOUT  (TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_data   (i_data),
    .o_req    (o_req),
    .o_data   (o_data),
    .i_ack    (ack_w),
    .o_done   (o_done),
    .o_timeout(o_timeout),
    .o_busy   (o_busy)
  );

  always #5 clk = ~clk;

  // Destination model: follows o_req two cycles late, optionally at a random phase.
  always begin
    @(posedge clk);
    #2;
    if (!dest_en) begin
      dest_ack = 1'b0;
      dest_cnt = 0;
    end else if (o_req != dest_ack) begin
      if (dest_cnt >= 2) begin
        if (dest_jit) #($urandom_range(0, 6));
        dest_ack = o_req;
        dest_cnt = 0;
      end else begin
        dest_cnt++;
      end
    end else begin
      dest_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ack_level);
    rst_n = 1'b0; man_ack = ack_level; dest_en = 1'b0; dest_jit = 1'b0; i_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_cmp += 6;
    if (o_req !== 1'b0)     begin n_bad++; $display("FAIL reset_req: got %b want 0", o_req); end
    if (o_data !== 8'h00)   begin n_bad++; $display("FAIL reset_data: got %h want 00", o_data); end
    if (o_done !== 1'b0)    begin n_bad++; $display("FAIL reset_done: got %b want 0", o_done); end
    if (o_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b want 0", o_timeout); end
    if (o_busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    if (o_ready !== 1'b1)   begin n_bad++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (o_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_after: got %b want 1", o_ready); end
    $display("reset: outputs checked during and after reset");
  endtask

  task automatic test_single();
    // Accept at E0; ack raised after E2 -> req falls after E6; ack dropped after E8 -> done after E12.
    i_valid = 1'b1; i_data = 8'hA5;
    tick();
    i_valid = 1'b0;
    n_cmp += 3;
    if (o_req !== 1'b1)   begin n_bad++; $display("FAIL single_req_rise: got %b want 1", o_req); end
    if (o_busy !== 1'b1)  begin n_bad++; $display("FAIL single_busy_rise: got %b want 1", o_busy); end
    if (o_ready !== 1'b0) begin n_bad++; $display("FAIL single_ready_fall: got %b want 0", o_ready); end
    for (int n = 1; n <= 13; n++) begin
      tick();
      n_cmp += 5;
      if (o_data !== 8'hA5)          begin n_bad++; $display("FAIL single_data n=%0d: got %h want a5", n, o_data); end
      if (o_req !== (n < 6))         begin n_bad++; $display("FAIL single_req n=%0d: got %b want %b", n, o_req, n < 6); end
      if (o_done !== (n == 12))      begin n_bad++; $display("FAIL single_done n=%0d: got %b want %b", n, o_done, n == 12); end
      if (o_ready !== (n >= 12))     begin n_bad++; $display("FAIL single_ready n=%0d: got %b want %b", n, o_ready, n >= 12); end
      if (o_timeout !== 1'b0)        begin n_bad++; $display("FAIL single_timeout n=%0d: got %b want 0", n, o_timeout); end
      if (n == 2) man_ack = 1'b1;
      if (n == 8) man_ack = 1'b0;
    end
    $display("single: word a5 sent, acceptance-to-ready 12 cycles");
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    int k = 0, dones = 0;
    logic prev_ready, done_seen, acc;
    logic [7:0] prev_data;
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    dest_en = 1'b1;
    i_valid = 1'b1; i_data = words[0];
    prev_ready = o_ready; prev_data = o_data; done_seen = 1'b0;
    for (int cyc = 0; cyc < 200 && !(k == 3 && dones == 3); cyc++) begin
      tick();
      acc = prev_ready && i_valid;
      n_cmp++;
      if (done_seen && k < 3 && !acc) begin n_bad++; $display("FAIL b2b_bubble: no acceptance after done, k=%0d", k); end
      if (acc) begin
        n_cmp++;
        if (o_data !== words[k]) begin n_bad++; $display("FAIL b2b_data k=%0d: got %h want %h", k, o_data, words[k]); end
        $display("b2b: word %0d = %h accepted", k, o_data);
        k++;
        if (k < 3) i_data = words[k]; else i_valid = 1'b0;
      end else if (o_data !== prev_data) begin
        n_bad++; $display("FAIL b2b_hold: got %h want %h", o_data, prev_data);
      end
      done_seen = 1'b0;
      if (o_done) begin
        dones++;
        done_seen = 1'b1;
        n_cmp++;
        if (o_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_at_done: got %b want 1", o_ready); end
      end
      prev_ready = o_ready; prev_data = o_data;
    end
    n_cmp += 2;
    if (k != 3)     begin n_bad++; $display("FAIL b2b_accepts: got %0d want 3", k); end
    if (dones != 3) begin n_bad++; $display("FAIL b2b_dones: got %0d want 3", dones); end
    dest_en = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int cnt;
    i_valid = 1'b1; i_data = 8'h3C;
    tick();
    i_valid = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      tick();
      n_cmp += 2;
      if (o_timeout !== (n == 16)) begin n_bad++; $display("FAIL tmo_pulse n=%0d: got %b want %b", n, o_timeout, n == 16); end
      if (o_req !== 1'b1)          begin n_bad++; $display("FAIL tmo_req n=%0d: got %b want 1", n, o_req); end
    end
    man_ack = 1'b1;
    cnt = 0;
    while (o_req && cnt < 10) begin tick(); cnt++; end
    n_cmp++;
    if (o_req !== 1'b0) begin n_bad++; $display("FAIL tmo_late_ack: req still %b after %0d cycles", o_req, cnt); end
    man_ack = 1'b0;
    cnt = 0;
    while (!o_done && cnt < 10) begin
      tick(); cnt++;
      n_cmp++;
      if (o_timeout !== 1'b0) begin n_bad++; $display("FAIL tmo_second: got %b want 0", o_timeout); end
    end
    n_cmp += 2;
    if (o_done !== 1'b1)   begin n_bad++; $display("FAIL tmo_done: got %b want 1", o_done); end
    if (o_data !== 8'h3C)  begin n_bad++; $display("FAIL tmo_data: got %h want 3c", o_data); end
    $display("timeout: word 3c, one timeout pulse, late ack completed");
    tick();
  endtask

  task automatic test_stale_ack();
    int cnt;
    rst_n = 1'b0; man_ack = 1'b1;
    tick();
    n_cmp++;
    if (o_ready !== 1'b1) begin n_bad++; $display("FAIL stale_ready_in_reset: got %b want 1", o_ready); end
    rst_n = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if (o_ready !== 1'b0) begin n_bad++; $display("FAIL stale_ready_blocked: got %b want 0", o_ready); end
    i_valid = 1'b1; i_data = 8'h77;
    for (int n = 0; n < 5; n++) begin
      tick();
      n_cmp += 3;
      if (o_ready !== 1'b0) begin n_bad++; $display("FAIL stale_ready n=%0d: got %b want 0", n, o_ready); end
      if (o_req !== 1'b0)   begin n_bad++; $display("FAIL stale_req n=%0d: got %b want 0", n, o_req); end
      if (o_data !== 8'h00) begin n_bad++; $display("FAIL stale_data n=%0d: got %h want 00", n, o_data); end
    end
    man_ack = 1'b0;
    cnt = 0;
    while (!o_ready && cnt < 10) begin tick(); cnt++; end
    n_cmp++;
    if (cnt != NB) begin n_bad++; $display("FAIL stale_release: ready after %0d cycles want %0d", cnt, NB); end
    tick();
    i_valid = 1'b0;
    n_cmp += 2;
    if (o_req !== 1'b1)   begin n_bad++; $display("FAIL stale_accept_req: got %b want 1", o_req); end
    if (o_data !== 8'h77) begin n_bad++; $display("FAIL stale_accept_data: got %h want 77", o_data); end
    $display("stale_ack: blocked until ack released, then word 77 accepted");
  endtask

  task automatic test_reset_mid_op();
    int cnt;
    do_reset(1'b0);
    tick();
    i_valid = 1'b1; i_data = 8'h5A;
    tick();
    i_valid = 1'b0;
    man_ack = 1'b1;
    tick();
    n_cmp++;
    if (o_req !== 1'b1) begin n_bad++; $display("FAIL mid_req_before: got %b want 1", o_req); end
    #4 rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (o_req !== 1'b0)   begin n_bad++; $display("FAIL mid_req_async: got %b want 0", o_req); end
    if (o_busy !== 1'b0)  begin n_bad++; $display("FAIL mid_busy: got %b want 0", o_busy); end
    if (o_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready_in_reset: got %b want 1", o_ready); end
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if (o_ready !== 1'b0) begin n_bad++; $display("FAIL mid_ready_blocked: got %b want 0", o_ready); end
    man_ack = 1'b0;
    cnt = 0;
    while (!o_ready && cnt < 10) begin tick(); cnt++; end
    n_cmp++;
    if (cnt != NB) begin n_bad++; $display("FAIL mid_release: ready after %0d cycles want %0d", cnt, NB); end
    $display("reset_mid_op: req dropped asynchronously, ready after ack release");
  endtask

  task automatic test_jitter();
    logic [7:0] words [8];
    int k = 0, dones = 0;
    logic prev_ready, prev_busy, acc;
    logic [7:0] prev_data;
    do_reset(1'b0);
    tick();
    for (int i = 0; i < 8; i++) words[i] = 8'($urandom_range(0, 255));
    dest_en = 1'b1; dest_jit = 1'b1;
    i_valid = 1'b1; i_data = words[0];
    prev_ready = o_ready; prev_data = o_data; prev_busy = o_busy;
    for (int cyc = 0; cyc < 400 && !(k == 8 && dones == 8); cyc++) begin
      tick();
      acc = prev_ready && i_valid;
      if (acc) begin
        n_cmp++;
        if (o_data !== words[k]) begin n_bad++; $display("FAIL jit_data k=%0d: got %h want %h", k, o_data, words[k]); end
        $display("jitter: word %0d = %h accepted", k, o_data);
        k++;
        if (k < 8) i_data = words[k]; else i_valid = 1'b0;
      end else if (prev_busy && o_data !== prev_data) begin
        n_cmp++;
        n_bad++; $display("FAIL jit_hold: got %h want %h while busy", o_data, prev_data);
      end
      if (o_done) dones++;
      prev_ready = o_ready; prev_data = o_data; prev_busy = o_busy;
    end
    n_cmp += 2;
    if (k != 8)     begin n_bad++; $display("FAIL jit_accepts: got %0d want 8", k); end
    if (dones != 8) begin n_bad++; $display("FAIL jit_dones: got %0d want 8", dones); end
    dest_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_stale_ack();
    test_reset_mid_op();
    test_jitter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
